sr_drive_seq: RTL and testbench
===============================

# sr_drive_seq

Sequencing driver that turns a stream of target bit values into legal S/R excitation pulses for a downstream SR flip-flop, then confirms the flip-flop reached the requested state. It sits between control logic and an SR flip-flop instance: control logic presents target bits over a valid/ready handshake, and this block computes the excitation and holds it for a programmable number of cycles. It never issues the forbidden S=R=1 combination, and it keeps a shadow copy of the flip-flop state.

## Interface
Parameters:
- HOLD_CYCLES, default 1: cycles S or R is held asserted per transfer; 0 is treated as 1.
- CNT_W, default 8: width of the completed-transfer counter.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  target bit offered.
- in_ready  output  1  block can accept a target (high only in IDLE).
- in_bit  input  1  requested next state of the flip-flop.
- s  output  1  set excitation to the flip-flop, registered.
- r  output  1  reset excitation to the flip-flop, registered.
- q_fb  input  1  flip-flop q, fed back.
- done  output  1  one-cycle pulse when a transfer completes.
- err  output  1  sticky mismatch flag (only with verify enabled).
- cur_q  output  1  shadow of the flip-flop state.
- tx_count  output  CNT_W  completed transfers, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, DRIVE, CHECK.
- Reset values (rst_n low at a posedge): state=IDLE, s=0, r=0, done=0, err=0, cur_q=0, shadow_valid=0, tx_count=0, hold counter=0.
- IDLE:
  - in_ready=1.
  - When in_valid is high, latch in_bit as target and move to DRIVE.
- Excitation is computed once at accept:
  - If shadow_valid=0, the block forces a drive: target 1 gives s=1; target 0 gives r=1.
  - If shadow_valid=1 and target equals cur_q, this is a hold transfer: s=0, r=0.
  - If shadow_valid=1, target=1 and cur_q=0, then s=1.
  - If shadow_valid=1, target=0 and cur_q=1, then r=1.
- s and r are never both 1, in any state or under any input.
- DRIVE:
  - Lasts exactly max(HOLD_CYCLES,1) cycles with the computed s/r.
  - Hold transfers still spend these cycles, with s=r=0.
  - Then move to CHECK.
- CHECK:
  - One cycle with s=r=0.
  - Samples q_fb (when verify is compiled in).
  - On exit: cur_q=target, shadow_valid=1, tx_count+1, done=1 for one cycle, and return to IDLE.
- in_valid is ignored outside IDLE. in_bit only needs to be stable in the accept cycle.
- tx_count wraps from all-ones to 0 without any flag.
- Reset mid-transfer aborts it:
  - s and r are 0 from the reset edge onward.
  - There is no done pulse and tx_count is not incremented.

## Timing
- Accept at edge k (IDLE, in_valid=1).
- s/r are asserted in cycles k+1 through k+H, where H=max(HOLD_CYCLES,1).
- CHECK occupies cycle k+H+1.
- done and in_ready are both high in cycle k+H+2.
- Latency from accept to done is H+2 cycles.
- A new transfer can be accepted in the done cycle, so back-to-back throughput is one transfer per H+2 cycles.
- q_fb is expected valid during CHECK, because the flip-flop captured the last excitation at the edge closing cycle k+H.

## Configuration
- SR_DRV_VERIFY_EN defined:
  - In CHECK, if q_fb differs from target, err is set and stays 1 until rst_n.
  - The transfer still completes: done pulses and cur_q takes the target, not q_fb.
- SR_DRV_VERIFY_EN undefined:
  - There is no feedback check; q_fb is unused.
  - err is tied to 0.
  - Timing is identical in both cases.

## Test plan
- Reset, then target 1 with HOLD_CYCLES=1 -> forced drive:
  - s=1 for exactly 1 cycle, r=0.
  - done pulses 3 cycles after accept.
  - cur_q=1, tx_count=1.
- From cur_q=1, target 0 with HOLD_CYCLES=3 -> r=1 for 3 cycles, s=0, done at accept+5, cur_q=0.
- From cur_q=0, target 0 -> hold transfer:
  - s=r=0 throughout.
  - done at accept+H+2.
  - tx_count increments.
- Back-to-back stream 1,0,1,1 with in_valid held high:
  - Accepts land on the done cycles.
  - s/r are never both 1.
  - Final cur_q=1, tx_count=4.
- With SR_DRV_VERIFY_EN, q_fb held 0 while target 1 is driven -> err=1 after CHECK and stays 1 through later correct transfers until rst_n.
- rst_n low during the second DRIVE cycle of an H=3 transfer:
  - s=r=0 at the next edge.
  - State is IDLE with no done pulse.
  - tx_count is unchanged from its reset value of 0.

Source files
------------

// File: rtl/sr_drive_seq.sv
// Sequencing driver that turns target bits into legal S/R pulses for a downstream SR flip-flop.
// Define SR_DRV_VERIFY_EN to compare q_fb against the target in CHECK and raise a sticky err.
module sr_drive_seq #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  output logic             done,
  output logic             err,
  output logic             cur_q,
  output logic [CNT_W-1:0] tx_count
);

  localparam int unsigned Hold  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HoldW = (Hold > 1) ? $clog2(Hold) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(Hold - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e             state_q, state_d;
  logic               s_q, s_d, r_q, r_d;
  logic               done_q, done_d;
  logic               cur_q_q, cur_q_d;
  logic               shadow_valid_q, shadow_valid_d;
  logic               target_q, target_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               err_q, err_d;

  always_comb begin
    state_d        = state_q;
    s_d            = 1'b0;
    r_d            = 1'b0;
    done_d         = 1'b0;
    cur_q_d        = cur_q_q;
    shadow_valid_d = shadow_valid_q;
    target_d       = target_q;
    tx_count_d     = tx_count_q;
    hold_cnt_d     = hold_cnt_q;
    err_d          = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StDrive;
          target_d   = in_bit;
          hold_cnt_d = HoldLast;
          // Without a known shadow the flip-flop state is unknown, so always drive.
          if (!shadow_valid_q) begin
            s_d = in_bit;
            r_d = ~in_bit;
          end else begin
            s_d = in_bit & ~cur_q_q;
            r_d = ~in_bit & cur_q_q;
          end
        end
      end
      StDrive: begin
        if (hold_cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          s_d        = s_q;
          r_d        = r_q;
          hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
      end
      StCheck: begin
        state_d        = StIdle;
        cur_q_d        = target_q;
        shadow_valid_d = 1'b1;
        tx_count_d     = tx_count_q + CNT_W'(1);
        done_d         = 1'b1;
`ifdef SR_DRV_VERIFY_EN
        if (q_fb != target_q) err_d = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      done_q         <= 1'b0;
      cur_q_q        <= 1'b0;
      shadow_valid_q <= 1'b0;
      target_q       <= 1'b0;
      tx_count_q     <= '0;
      hold_cnt_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      r_q            <= r_d;
      done_q         <= done_d;
      cur_q_q        <= cur_q_d;
      shadow_valid_q <= shadow_valid_d;
      target_q       <= target_d;
      tx_count_q     <= tx_count_d;
      hold_cnt_q     <= hold_cnt_d;
      err_q          <= err_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign s        = s_q;
  assign r        = r_q;
  assign done     = done_q;
  assign cur_q    = cur_q_q;
  assign tx_count = tx_count_q;

`ifdef SR_DRV_VERIFY_EN
  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb ^ err_q;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_seq.sv
// Directed bench for sr_drive_seq: one instance with HOLD_CYCLES=1, one with HOLD_CYCLES=3
// and a 2-bit counter, each fed back from a behavioural SR flip-flop.
module tb_sr_drive_seq;

`ifdef SR_DRV_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic vld    = 1'b0;
  logic bit_in = 1'b0;
  logic sel    = 1'b0;
  logic stuck1 = 1'b0;

  logic s1, r1, rdy1, done1, err1, cq1, ff1 = 1'b0;
  logic s3, r3, rdy3, done3, err3, cq3, ff3 = 1'b0;
  logic [7:0] tx1;
  logic [1:0] tx3;

  sr_drive_seq #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld & ~sel), .in_ready(rdy1), .in_bit(bit_in),
    .s(s1), .r(r1), .q_fb(stuck1 ? 1'b0 : ff1), .done(done1), .err(err1), .cur_q(cq1),
    .tx_count(tx1)
  );

  sr_drive_seq #(.HOLD_CYCLES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld & sel), .in_ready(rdy3), .in_bit(bit_in),
    .s(s3), .r(r3), .q_fb(ff3), .done(done3), .err(err3), .cur_q(cq3), .tx_count(tx3)
  );

  // Behavioural SR flip-flops downstream of each driver.
  always @(posedge clk) begin
    if (s1) ff1 <= 1'b1; else if (r1) ff1 <= 1'b0;
    if (s3) ff3 <= 1'b1; else if (r3) ff3 <= 1'b0;
  end

  logic       m_s, m_r, m_rdy, m_done, m_err, m_cq;
  logic [7:0] m_tx;
  assign m_s    = sel ? s3    : s1;
  assign m_r    = sel ? r3    : r1;
  assign m_rdy  = sel ? rdy3  : rdy1;
  assign m_done = sel ? done3 : done1;
  assign m_err  = sel ? err3  : err1;
  assign m_cq   = sel ? cq3   : cq1;
  assign m_tx   = sel ? {6'b0, tx3} : tx1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_eq("sr_excl_h1", {31'b0, s1 & r1}, 32'd0);
      check_eq("sr_excl_h3", {31'b0, s3 & r3}, 32'd0);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at a negedge with the selected DUT idle; returns at the negedge of the done cycle.
  task automatic xfer(input int h, input bit b, input bit es, input bit er, input int ecnt,
                      input bit keep_valid);
    vld    = 1'b1;
    bit_in = b;
    @(negedge clk);
    if (!keep_valid) vld = 1'b0;
    bit_in = ~b;
    for (int i = 0; i < h; i++) begin
      check_eq("drive_s", m_s, es);
      check_eq("drive_r", m_r, er);
      check_eq("drive_rdy", m_rdy, 1'b0);
      check_eq("drive_done", m_done, 1'b0);
      @(negedge clk);
    end
    check_eq("check_s", m_s, 1'b0);
    check_eq("check_r", m_r, 1'b0);
    check_eq("check_done", m_done, 1'b0);
    check_eq("check_rdy", m_rdy, 1'b0);
    @(negedge clk);
    check_eq("done_pulse", m_done, 1'b1);
    check_eq("done_rdy", m_rdy, 1'b1);
    check_eq("done_cur_q", m_cq, b);
    check_eq("done_tx", m_tx, ecnt);
  endtask

  task automatic check_reset_state();
    check_eq("rst_rdy", m_rdy, 1'b1);
    check_eq("rst_s", m_s, 1'b0);
    check_eq("rst_r", m_r, 1'b0);
    check_eq("rst_done", m_done, 1'b0);
    check_eq("rst_err", m_err, 1'b0);
    check_eq("rst_cur_q", m_cq, 1'b0);
    check_eq("rst_tx", m_tx, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    sel = 1'b0; check_reset_state();
    sel = 1'b1; check_reset_state();

    // Forced drive, H=1.
    sel = 1'b0;
    xfer(1, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    @(negedge clk);
    check_eq("done_one_cycle", m_done, 1'b0);

    // H=3: forced set, then reset drive, hold transfer, and counter wrap.
    sel = 1'b1;
    xfer(3, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    xfer(3, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    xfer(3, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    xfer(3, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Back-to-back stream 1,0,1,1 with in_valid held high.
    do_reset();
    sel = 1'b0;
    xfer(1, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    xfer(1, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    xfer(1, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    xfer(1, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    vld = 1'b0;
    @(negedge clk);
    check_eq("stream_idle_done", m_done, 1'b0);
    check_eq("stream_cur_q", m_cq, 1'b1);
    check_eq("stream_tx", m_tx, 32'd4);

    // Feedback stuck at 0 while driving 1.
    do_reset();
    stuck1 = 1'b1;
    xfer(1, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    check_eq("err_after_bad", m_err, VerifyEn);
    stuck1 = 1'b0;
    xfer(1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    check_eq("err_sticky", m_err, VerifyEn);
    do_reset();
    check_eq("err_cleared", m_err, 1'b0);

    // Reset during the second DRIVE cycle of an H=3 transfer.
    sel    = 1'b1;
    vld    = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    check_eq("abort_s_first", m_s, 1'b1);
    @(negedge clk);
    check_eq("abort_s_second", m_s, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_s", m_s, 1'b0);
    check_eq("abort_r", m_r, 1'b0);
    check_eq("abort_rdy", m_rdy, 1'b1);
    check_eq("abort_done", m_done, 1'b0);
    check_eq("abort_tx", m_tx, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_abort_done", m_done, 1'b0);
      check_eq("post_abort_s", m_s, 1'b0);
      check_eq("post_abort_tx", m_tx, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
